// File: rtl/spi_cmd_slave.sv
// spi_cmd_slave: SPI responder (CPOL=0, CPHA=1, MSB first) oversampled on clk_12mhz.
// Receives two-byte command frames (command byte, data byte) and presents each complete
// write frame as a one-cycle strobe. The RD_CMD command captures {count_p, count_m} and
// shifts the 2*CNT_W bits out on spi_miso.
// Optional build macro SPI_MISO_TRISTATE_EN: spi_miso floats unless this responder is
// selected and busy, so several responders can share the line.
module spi_cmd_slave #(
    parameter logic [7:0] RD_CMD      = 8'h05,
    parameter int         SYNC_STAGES = 2,
    parameter int         CNT_W       = 24
) (
    input  logic             clk_12mhz,
    input  logic             rst,
    input  logic             spi_clk,
    input  logic             spi_mosi,
    input  logic             spi_cs,
    output logic             spi_miso,
    input  logic [CNT_W-1:0] count_p,
    input  logic [CNT_W-1:0] count_m,
    output logic             wr_valid,
    output logic [7:0]       wr_cmd,
    output logic [7:0]       wr_data,
    output logic             rd_strobe,
    output logic             busy,
    output logic             frame_err
);

    localparam int TX_W     = 2 * CNT_W;
    localparam int CNT_BITS = $clog2(TX_W + 1);
    localparam logic [CNT_BITS-1:0] LAST_BIT = CNT_BITS'(7);
    localparam logic [CNT_BITS-1:0] TX_LAST  = CNT_BITS'(TX_W);

    typedef enum logic [2:0] {IDLE, CMD, DATA, READ, IGNORE} state_t;

    // Synchroniser chain for {cs, mosi, sck}. Stages reset to 0 so that a reset released
    // while CS is already low never produces a false CS falling edge mid-frame.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic [2:0] stage_reg;
            if (gi == 0) begin : g_first
                // First stage samples the asynchronous pins
                always_ff @(posedge clk_12mhz) begin
                    if (!rst) stage_reg <= '0;
                    else      stage_reg <= {spi_cs, spi_mosi, spi_clk};
                end
            end else begin : g_next
                // Later stages settle metastability
                always_ff @(posedge clk_12mhz) begin
                    if (!rst) stage_reg <= '0;
                    else      stage_reg <= g_sync[gi-1].stage_reg;
                end
            end
        end
    endgenerate

    logic cs_s, mosi_s, sck_s;
    assign {cs_s, mosi_s, sck_s} = g_sync[SYNC_STAGES-1].stage_reg;

    logic [1:0] hist_reg;   // {cs, sck} delayed by one clock for edge detection

    // History flop for CS and SCK edge detection
    always_ff @(posedge clk_12mhz) begin
        if (!rst) hist_reg <= '0;
        else      hist_reg <= {cs_s, sck_s};
    end

    logic cs_rise, cs_fall, sck_rise, sck_fall;
    assign cs_rise  =  cs_s  & ~hist_reg[1];
    assign cs_fall  = ~cs_s  &  hist_reg[1];
    assign sck_rise =  sck_s & ~hist_reg[0];
    assign sck_fall = ~sck_s &  hist_reg[0];

    state_t              state_reg, state_next;
    logic [CNT_BITS-1:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0]          shift_reg, shift_next;
    logic [7:0]          cmd_hold_reg, cmd_hold_next;
    logic [TX_W-1:0]     tx_reg, tx_next;
    logic                miso_reg, miso_next;
    logic                wr_valid_reg, wr_valid_next;
    logic [7:0]          wr_cmd_reg, wr_cmd_next;
    logic [7:0]          wr_data_reg, wr_data_next;
    logic                rd_strobe_reg, rd_strobe_next;
    logic                busy_reg, busy_next;
    logic                frame_err_reg, frame_err_next;
    logic [7:0]          byte_in;

    assign byte_in = {shift_reg[6:0], mosi_s};

    // State and datapath registers
    always_ff @(posedge clk_12mhz) begin
        if (!rst) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            cmd_hold_reg  <= '0;
            tx_reg        <= '0;
            miso_reg      <= 1'b0;
            wr_valid_reg  <= 1'b0;
            wr_cmd_reg    <= '0;
            wr_data_reg   <= '0;
            rd_strobe_reg <= 1'b0;
            busy_reg      <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            cmd_hold_reg  <= cmd_hold_next;
            tx_reg        <= tx_next;
            miso_reg      <= miso_next;
            wr_valid_reg  <= wr_valid_next;
            wr_cmd_reg    <= wr_cmd_next;
            wr_data_reg   <= wr_data_next;
            rd_strobe_reg <= rd_strobe_next;
            busy_reg      <= busy_next;
            frame_err_reg <= frame_err_next;
        end
    end

    // Frame FSM: CS edges take priority over SCK, so a bit coinciding with CS rise is dropped
    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        cmd_hold_next  = cmd_hold_reg;
        tx_next        = tx_reg;
        miso_next      = miso_reg;
        wr_valid_next  = 1'b0;
        wr_cmd_next    = wr_cmd_reg;
        wr_data_next   = wr_data_reg;
        rd_strobe_next = 1'b0;
        busy_next      = busy_reg;
        frame_err_next = frame_err_reg;

        if (cs_rise) begin
            state_next   = IDLE;
            busy_next    = 1'b0;
            miso_next    = 1'b0;
            bit_cnt_next = '0;
            if (bit_cnt_reg != '0) frame_err_next = 1'b1;   // partial byte or partial readback
        end else if (cs_fall) begin
            // Also covers a CS fall outside IDLE: treated as a restart
            state_next   = CMD;
            busy_next    = 1'b1;
            miso_next    = 1'b0;
            bit_cnt_next = '0;
            shift_next   = '0;
        end else begin
            case (state_reg)
                IDLE: ;
                CMD: begin
                    if (sck_fall) begin
                        shift_next = byte_in;
                        if (bit_cnt_reg == LAST_BIT) begin
                            bit_cnt_next = '0;
                            if (byte_in == RD_CMD) begin
                                tx_next        = {count_p, count_m};
                                rd_strobe_next = 1'b1;
                                state_next     = READ;
                            end else begin
                                cmd_hold_next = byte_in;
                                state_next    = DATA;
                            end
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (sck_fall) begin
                        shift_next = byte_in;
                        if (bit_cnt_reg == LAST_BIT) begin
                            bit_cnt_next   = '0;
                            wr_cmd_next    = cmd_hold_reg;
                            wr_data_next   = byte_in;
                            wr_valid_next  = 1'b1;
                            frame_err_next = 1'b0;
                            state_next     = IGNORE;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 1'b1;
                        end
                    end
                end
                READ: begin
                    // bit_cnt counts bits driven; the last bit is held until its falling edge
                    if (sck_rise && bit_cnt_reg != TX_LAST) begin
                        miso_next    = tx_reg[TX_W-1];
                        tx_next      = {tx_reg[TX_W-2:0], 1'b0};
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end else if (sck_fall && bit_cnt_reg == TX_LAST) begin
                        miso_next    = 1'b0;
                        bit_cnt_next = '0;
                        state_next   = IGNORE;
                    end
                end
                IGNORE: begin
                    if (sck_fall) frame_err_next = 1'b1;   // overlong frame
                end
                default: state_next = IDLE;
            endcase
        end
    end

`ifdef SPI_MISO_TRISTATE_EN
    assign spi_miso = (rst && busy_reg && !cs_s) ? miso_reg : 1'bz;
`else
    assign spi_miso = miso_reg;
`endif

    assign wr_valid  = wr_valid_reg;
    assign wr_cmd    = wr_cmd_reg;
    assign wr_data   = wr_data_reg;
    assign rd_strobe = rd_strobe_reg;
    assign busy      = busy_reg;
    assign frame_err = frame_err_reg;

endmodule
